// File: rtl/gaus_pkg.sv
// Constants and state type shared by the Gaussian line-buffer shifter (read side)
// and the result packer (write side).
package gaus_pkg;
  localparam int PIXW       = 16;
  localparam int DATAW      = 64;
  localparam int PIXPERWORD = DATAW / PIXW;
  // Width of a lane index / pack counter.
  localparam int LANEIDXW   = $clog2(PIXPERWORD);

  typedef enum logic [1:0] {RUN, FLUSH_PEND, DONE} packState_t;
endpackage

// File: rtl/gaus_word_assembler.sv
// Lane register for gaus_result_packer: places pixels MSB lane first and keeps
// not-yet-filled lanes at zero so a flushed word comes out zero-padded.
module gaus_word_assembler
  import gaus_pkg::*;
#(
  parameter int PIXW  = gaus_pkg::PIXW,
  parameter int DATAW = gaus_pkg::DATAW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PIXW-1:0]     pixIn,
  input  logic                accept,
  input  logic                clear,
  output logic [LANEIDXW-1:0] packCount,
  output logic [DATAW-1:0]    curWord,
  output logic [DATAW-1:0]    insWord
);
  localparam int LANES = DATAW / PIXW;
  localparam logic [LANEIDXW-1:0] LASTCOUNT = LANEIDXW'(LANES - 1);

  // insWord is curWord with the incoming pixel dropped into lane (LANES-1-packCount).
  always_comb begin
    insWord = curWord;
    for (int i = 0; i < LANES; i++) begin
      if (i == LANES - 1 - int'(packCount)) insWord[i*PIXW +: PIXW] = pixIn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear || (accept && packCount == LASTCOUNT)) begin
      curWord   <= '0;
      packCount <= '0;
    end else if (accept) begin
      curWord   <= insWord;
      packCount <= packCount + LANEIDXW'(1);
    end
  end
endmodule

// File: rtl/gaus_result_packer.sv
// Packs filtered pixels four per word and writes them to sequential word addresses
// over [STARTADDRESS, ENDADDRESS]. Define PACK_LANE_MASK_EN to add the wrMask output.
module gaus_result_packer
  import gaus_pkg::*;
#(
  parameter int unsigned STARTADDRESS = 0,
  parameter int unsigned ENDADDRESS   = 4194303,
  parameter int          ADDRW        = 22,
  parameter int          PIXW         = gaus_pkg::PIXW,
  parameter int          DATAW        = gaus_pkg::DATAW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PIXW-1:0]       pixIn,
  input  logic                  pixValid,
  output logic                  pixReady,
  input  logic                  flush,
  input  logic                  frameStart,
  output logic [DATAW-1:0]      wrData,
  output logic [ADDRW-1:0]      wrAddr,
  output logic                  wrReq,
  input  logic                  wrAck,
`ifdef PACK_LANE_MASK_EN
  output logic [DATAW/PIXW-1:0] wrMask,
`endif
  output logic                  done
);
  localparam int LANES = DATAW / PIXW;
  localparam logic [LANEIDXW-1:0] LASTCOUNT = LANEIDXW'(LANES - 1);
  localparam logic [ADDRW-1:0]    FIRSTADDR = ADDRW'(STARTADDRESS);
  localparam logic [ADDRW-1:0]    LASTADDR  = ADDRW'(ENDADDRESS);

  packState_t          state;
  logic                startPend;
  logic [LANEIDXW-1:0] packCount;
  logic [DATAW-1:0]    curWord;
  logic [DATAW-1:0]    insWord;
  logic accept, xfer, endXfer, fullLoad, flushLoad, flushArm, asmClear;

  // A full word can only load while the output register is empty, so the fourth
  // pixel is held off while a word is still outstanding.
  always_comb begin
    pixReady  = (state == RUN) && !frameStart && ((packCount != LASTCOUNT) || !wrReq);
    accept    = pixValid && pixReady;
    xfer      = wrReq && wrAck;
    endXfer   = xfer && (wrAddr == LASTADDR) && !startPend && !frameStart;
    fullLoad  = accept && (packCount == LASTCOUNT);
    flushLoad = (state == FLUSH_PEND) && (!wrReq || wrAck) && !endXfer && !frameStart;
    flushArm  = (state == RUN) && flush && !fullLoad && ((packCount != '0) || accept)
                && !endXfer && !frameStart;
    asmClear  = frameStart || endXfer || flushLoad;
  end

  gaus_word_assembler #(
    .PIXW  (PIXW),
    .DATAW (DATAW)
  ) assembler (
    .clk       (clk),
    .reset     (reset),
    .pixIn     (pixIn),
    .accept    (accept),
    .clear     (asmClear),
    .packCount (packCount),
    .curWord   (curWord),
    .insWord   (insWord)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wrReq     <= 1'b0;
      wrData    <= '0;
      wrAddr    <= FIRSTADDR;
      done      <= 1'b0;
      startPend <= 1'b0;
`ifdef PACK_LANE_MASK_EN
      wrMask    <= '0;
`endif
    end else begin
      if (xfer) begin
        wrReq <= 1'b0;
        if (frameStart || startPend) begin
          wrAddr    <= FIRSTADDR;
          startPend <= 1'b0;
        end else if (wrAddr == LASTADDR) begin
          wrAddr <= FIRSTADDR;
          done   <= 1'b1;
          state  <= DONE;
        end else begin
          wrAddr <= wrAddr + ADDRW'(1);
        end
      end
      // A restart during an outstanding write defers the address reset to its transfer.
      if (frameStart) begin
        done  <= 1'b0;
        state <= RUN;
        if (wrReq && !wrAck) startPend <= 1'b1;
        else if (!wrReq)     wrAddr    <= FIRSTADDR;
      end else if (fullLoad) begin
        wrReq  <= 1'b1;
        wrData <= insWord;
`ifdef PACK_LANE_MASK_EN
        wrMask <= '1;
`endif
      end else if (flushLoad) begin
        wrReq  <= 1'b1;
        wrData <= curWord;
        state  <= RUN;
`ifdef PACK_LANE_MASK_EN
        wrMask <= ~({LANES{1'b1}} >> packCount);
`endif
      end else if (flushArm) begin
        state <= FLUSH_PEND;
      end
    end
  end
endmodule
